// File: rtl/mul_scheduler.sv
// mul_scheduler: round-robin arbiter and sequencer that feeds 32x32 multiply
// requests from two ports through one shared shift-add multiplier datapath.
module mul_scheduler #(
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_product,
  output logic        rsp_overflow,
  output logic        rsp_timeout,
  output logic [31:0] dp_multiplicand,
  output logic [31:0] dp_multiplier,
  output logic        dp_reset,
  output logic        dp_load,
  output logic        dp_show_result,
  input  logic        dp_done,
  input  logic        dp_overflow,
  input  logic [64:0] dp_result
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    RUN,
    READ,
    RESP
  } state_t;

  state_t        state;
  logic          rr;
  logic [31:0]   op_a;
  logic [31:0]   op_b;
  logic [CW-1:0] run_cnt;
  logic          grant_valid;
  logic          grant_id;
  logic          dp_result_unused;

  assign dp_result_unused = dp_result[64];

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (state == IDLE && !reset) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = rr;
      end else if (req0_valid || req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = req1_valid;
      end
    end
  end

  assign req0_ready      = grant_valid && !grant_id;
  assign req1_ready      = grant_valid && grant_id;
  assign dp_multiplicand = op_a;
  assign dp_multiplier   = op_b;
  assign dp_reset        = reset || (state == CLEAR);
  assign dp_load         = (state == LOAD);
  // A timed-out operation passes through READ only to line up with the
  // normal response latency; its result is not read.
  assign dp_show_result  = (state == READ) && !rsp_timeout;
  assign rsp_valid       = (state == RESP);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    if (reset) begin
      state        <= IDLE;
      rr           <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
      run_cnt      <= '0;
      rsp_id       <= 1'b0;
      rsp_product  <= '0;
      rsp_overflow <= 1'b0;
      rsp_timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            op_a         <= grant_id ? req1_a : req0_a;
            op_b         <= grant_id ? req1_b : req0_b;
            rsp_id       <= grant_id;
            rsp_product  <= '0;
            rsp_overflow <= 1'b0;
            rsp_timeout  <= 1'b0;
            rr           <= ~grant_id;
            state        <= CLEAR;
          end
        end
        CLEAR: state <= LOAD;
        LOAD: begin
          run_cnt <= '0;
          state   <= RUN;
        end
        RUN: begin
          run_cnt      <= run_cnt + CW'(1);
          rsp_overflow <= rsp_overflow | dp_overflow;
          if (dp_done) begin
            state <= READ;
          end else if (run_cnt == CW'(TIMEOUT - 1)) begin
            rsp_timeout <= 1'b1;
            state       <= READ;
          end
        end
        READ: begin
          if (!rsp_timeout) rsp_product <= dp_result[63:0];
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_scheduler.sv
// Bench for mul_scheduler: a behavioural shift-add datapath per DUT and a
// scoreboard of expected responses filled at request acceptance.
module tb_mul_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req0_valid[2];
  logic        req0_ready[2];
  logic [31:0] req0_a[2];
  logic [31:0] req0_b[2];
  logic        req1_valid[2];
  logic        req1_ready[2];
  logic [31:0] req1_a[2];
  logic [31:0] req1_b[2];
  logic        rsp_valid[2];
  logic        rsp_ready[2];
  logic        rsp_id[2];
  logic [63:0] rsp_product[2];
  logic        rsp_overflow[2];
  logic        rsp_timeout[2];
  logic [31:0] dp_multiplicand[2];
  logic [31:0] dp_multiplier[2];
  logic        dp_reset[2];
  logic        dp_load[2];
  logic        dp_show_result[2];
  logic        dp_done[2];
  logic        dp_overflow[2];
  logic [64:0] dp_result[2];

  mul_scheduler #(.TIMEOUT(40)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid[0]), .req0_ready(req0_ready[0]),
    .req0_a(req0_a[0]), .req0_b(req0_b[0]),
    .req1_valid(req1_valid[0]), .req1_ready(req1_ready[0]),
    .req1_a(req1_a[0]), .req1_b(req1_b[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_id(rsp_id[0]),
    .rsp_product(rsp_product[0]), .rsp_overflow(rsp_overflow[0]),
    .rsp_timeout(rsp_timeout[0]),
    .dp_multiplicand(dp_multiplicand[0]), .dp_multiplier(dp_multiplier[0]),
    .dp_reset(dp_reset[0]), .dp_load(dp_load[0]),
    .dp_show_result(dp_show_result[0]), .dp_done(dp_done[0]),
    .dp_overflow(dp_overflow[0]), .dp_result(dp_result[0])
  );

  mul_scheduler #(.TIMEOUT(8)) dut_short (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid[1]), .req0_ready(req0_ready[1]),
    .req0_a(req0_a[1]), .req0_b(req0_b[1]),
    .req1_valid(req1_valid[1]), .req1_ready(req1_ready[1]),
    .req1_a(req1_a[1]), .req1_b(req1_b[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_id(rsp_id[1]),
    .rsp_product(rsp_product[1]), .rsp_overflow(rsp_overflow[1]),
    .rsp_timeout(rsp_timeout[1]),
    .dp_multiplicand(dp_multiplicand[1]), .dp_multiplier(dp_multiplier[1]),
    .dp_reset(dp_reset[1]), .dp_load(dp_load[1]),
    .dp_show_result(dp_show_result[1]), .dp_done(dp_done[1]),
    .dp_overflow(dp_overflow[1]), .dp_result(dp_result[1])
  );

  // Behavioural shift-add datapath: one multiplier bit consumed per cycle.
  for (genvar u = 0; u < 2; u++) begin : g_dp
    logic [63:0] mc;
    logic [63:0] prod;
    logic [31:0] mp;
    logic [64:0] sum;
    assign sum            = {1'b0, prod} + {1'b0, mc};
    assign dp_done[u]     = (mp == 32'd0);
    assign dp_overflow[u] = mp[0] & sum[64];
    assign dp_result[u]   = {1'b0, prod};
    always @(posedge clk) begin
      if (dp_reset[u]) begin
        prod <= '0;
        mc   <= '0;
        mp   <= '0;
      end else if (dp_load[u]) begin
        mc <= {32'd0, dp_multiplicand[u]};
        mp <= dp_multiplier[u];
      end else if (mp != 32'd0) begin
        if (mp[0]) prod <= sum[63:0];
        mc <= mc << 1;
        mp <= mp >> 1;
      end
    end
  end

  typedef struct packed {
    logic        id;
    logic [63:0] prod;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] pend0[$];
  logic [63:0] pend1[$];
  logic        id_log[$];

  int cyc = 0;
  int n_clr = 0;
  int n_load = 0;
  int n_show = 0;
  int n_both = 0;
  int total = 0;
  int bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dp_reset[0]) n_clr <= n_clr + 1;
    if (dp_load[0]) n_load <= n_load + 1;
    if (dp_show_result[0]) n_show <= n_show + 1;
    if (req0_ready[0] && req1_ready[0]) n_both <= n_both + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int run_len(input logic [31:0] b, input int tmo);
    int r = 1;
    for (int i = 0; i < 32; i++) if (b[i]) r = i + 2;
    return (r > tmo) ? tmo : r;
  endfunction

  task automatic drive();
    req0_valid[0] = (pend0.size() != 0);
    req1_valid[0] = (pend1.size() != 0);
    if (pend0.size() != 0) begin
      req0_a[0] = pend0[0][63:32];
      req0_b[0] = pend0[0][31:0];
    end
    if (pend1.size() != 0) begin
      req1_a[0] = pend1[0][63:32];
      req1_b[0] = pend1[0][31:0];
    end
  endtask

  // Called at a negedge: a visible ready means acceptance on the next edge.
  task automatic take_accepts();
    exp_t        e;
    logic [63:0] op;
    if (req0_ready[0] || req1_ready[0]) begin
      e.id = req1_ready[0];
      if ((e.id && pend1.size() == 0) || (!e.id && pend0.size() == 0)) begin
        check("spurious_ready", 64'd1, 64'd0);
      end else begin
        op     = e.id ? pend1.pop_front() : pend0.pop_front();
        e.prod = {32'd0, op[63:32]} * {32'd0, op[31:0]};
        e.due  = cyc + 4 + run_len(op[31:0], 40);
        sb.push_back(e);
      end
    end
  endtask

  task automatic service(input int n, input int budget);
    int   got = 0;
    exp_t e;
    for (int k = 0; k < budget && got < n; k++) begin
      @(negedge clk);
      take_accepts();
      if (rsp_valid[0] && rsp_ready[0]) begin
        got++;
        id_log.push_back(rsp_id[0]);
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_id", 64'(rsp_id[0]), 64'(e.id));
          check("rsp_product", rsp_product[0], e.prod);
          check("rsp_timeout", 64'(rsp_timeout[0]), 64'd0);
          check("rsp_overflow", 64'(rsp_overflow[0]), 64'd0);
          check("rsp_latency", 64'(cyc), 64'(e.due));
        end
      end
      @(posedge clk);
      #1;
      drive();
    end
    check("service_count", 64'(got), 64'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c0, l0, s0, t0, spent;
    logic seen;
    exp_t e;

    reset = 1'b1;
    rsp_ready[0] = 1'b1;
    rsp_ready[1] = 1'b1;
    req0_valid[1] = 1'b0; req0_a[1] = '0; req0_b[1] = '0;
    req1_valid[1] = 1'b0; req1_a[1] = '0; req1_b[1] = '0;
    req0_a[0] = '0; req0_b[0] = '0; req1_a[0] = '0; req1_b[0] = '0;
    pend0.push_back({32'd100, 32'd200});
    pend0.push_back({32'h0000_DEAD, 32'h0000_BEEF});
    pend1.push_back({32'h1234_5678, 32'h9ABC_DEF0});
    pend1.push_back({32'd1, 32'hFFFF_FFFF});
    drive();

    // Reset state, with both ports already requesting.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    check("rst_req0_ready", 64'(req0_ready[0]), 64'd0);
    check("rst_req1_ready", 64'(req1_ready[0]), 64'd0);
    check("rst_dp_reset", 64'(dp_reset[0]), 64'd1);
    check("rst_dp_load", 64'(dp_load[0]), 64'd0);
    check("rst_product", rsp_product[0], 64'd0);
    check("rst_multiplicand", 64'(dp_multiplicand[0]), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Arbitration from reset with both ports continuously valid.
    service(4, 300);
    check("arb_count", 64'(id_log.size()), 64'd4);
    if (id_log.size() == 4) begin
      check("arb_id0", 64'(id_log[0]), 64'd0);
      check("arb_id1", 64'(id_log[1]), 64'd1);
      check("arb_id2", 64'(id_log[2]), 64'd0);
      check("arb_id3", 64'(id_log[3]), 64'd1);
    end

    // Single request with pulse accounting.
    c0 = n_clr; l0 = n_load; s0 = n_show;
    pend0.push_back({32'd3, 32'd5});
    drive();
    service(1, 50);
    check("single_dp_reset_pulses", 64'(n_clr - c0), 64'd1);
    check("single_dp_load_pulses", 64'(n_load - l0), 64'd1);
    check("single_dp_show_pulses", 64'(n_show - s0), 64'd1);

    // Zero multiplier, then a tiny product to prove the clear in between.
    pend0.push_back({32'h0000_1234, 32'd0});
    drive();
    service(1, 50);
    pend0.push_back({32'd7, 32'd1});
    drive();
    service(1, 50);

    // Full range operands.
    pend0.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFF});
    drive();
    service(1, 100);
    check("never_both_ready", 64'(n_both), 64'd0);

    // Backpressure: response held while port 1 keeps requesting.
    rsp_ready[0] = 1'b0;
    pend0.push_back({32'd11, 32'd13});
    pend1.push_back({32'd5, 32'd6});
    drive();
    spent = 0;
    seen  = 1'b0;
    while (!seen && spent < 200) begin
      @(negedge clk);
      take_accepts();
      seen = rsp_valid[0];
      if (!seen) begin
        @(posedge clk);
        #1;
        drive();
      end
      spent++;
    end
    check("bp_rsp_seen", 64'(seen), 64'd1);
    check("bp_sb_depth", 64'(sb.size()), 64'd1);
    e = (sb.size() != 0) ? sb[0] : '0;
    check("bp_latency", 64'(cyc), 64'(e.due));
    for (int k = 0; k < 10; k++) begin
      check("bp_valid", 64'(rsp_valid[0]), 64'd1);
      check("bp_id", 64'(rsp_id[0]), 64'(e.id));
      check("bp_product", rsp_product[0], e.prod);
      check("bp_timeout", 64'(rsp_timeout[0]), 64'd0);
      check("bp_ready_low", 64'({req0_ready[0], req1_ready[0]}), 64'd0);
      @(posedge clk);
      #1;
      drive();
      @(negedge clk);
      take_accepts();
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    drive();
    if (sb.size() != 0) void'(sb.pop_front());
    service(1, 60);

    // Reset in the middle of RUN drops the operation.
    pend0.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFF});
    drive();
    spent = 0;
    while (sb.size() == 0 && spent < 50) begin
      @(negedge clk);
      take_accepts();
      @(posedge clk);
      #1;
      drive();
      spent++;
    end
    check("mid_rst_accepted", 64'(sb.size()), 64'd1);
    sb.delete();
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    pend0.push_back({32'd9, 32'd10});
    drive();
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    check("mid_rst_req0_ready", 64'(req0_ready[0]), 64'd0);
    check("mid_rst_dp_load", 64'(dp_load[0]), 64'd0);
    check("mid_rst_dp_show", 64'(dp_show_result[0]), 64'd0);
    check("mid_rst_dp_reset", 64'(dp_reset[0]), 64'd1);
    check("mid_rst_product", rsp_product[0], 64'd0);
    check("mid_rst_multiplier", 64'(dp_multiplier[0]), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    service(1, 60);

    // Timeout on the short-limit instance.
    req0_a[1] = 32'd3;
    req0_b[1] = 32'h8000_0000;
    req0_valid[1] = 1'b1;
    t0 = -1;
    for (int k = 0; k < 20 && t0 < 0; k++) begin
      @(negedge clk);
      if (req0_ready[1]) t0 = cyc;
      @(posedge clk);
      #1;
    end
    req0_valid[1] = 1'b0;
    check("tmo_accepted", 64'(t0 >= 0), 64'd1);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = rsp_valid[1];
      if (seen) begin
        check("tmo_latency", 64'(cyc), 64'(t0 + 12));
        check("tmo_flag", 64'(rsp_timeout[1]), 64'd1);
        check("tmo_product", rsp_product[1], 64'd0);
        check("tmo_id", 64'(rsp_id[1]), 64'd0);
      end
    end
    check("tmo_rsp_seen", 64'(seen), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
